// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: registers decode operands/controls, forwards rs1/rs2 from
// EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles on flush/stall.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold_i,
    input  logic               flush_i,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]    id_RD1,
    input  logic [XLEN-1:0]    id_RD2,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_ALUSrc,
    input  logic               id_RegWrite,
    input  logic               id_MemRead,
    input  logic [RADDR_W-1:0] ex_mem_rd,
    input  logic               ex_mem_RegWrite,
    input  logic [XLEN-1:0]    ex_mem_result,
    input  logic [RADDR_W-1:0] mem_wb_rd,
    input  logic               mem_wb_RegWrite,
    input  logic [XLEN-1:0]    mem_wb_data,
    output logic               ex_valid,
    output logic               ex_ALUSrc,
    output logic               ex_RegWrite,
    output logic               ex_MemRead,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [XLEN-1:0]    ex_A,
    output logic [XLEN-1:0]    ex_RD2,
    output logic [XLEN-1:0]    ex_imm,
    output logic               load_use_stall
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]        bubble_cnt
`endif
);

    logic               valid_q;
    logic               alusrc_q;
    logic               regwrite_q;
    logic               memread_q;
    logic [RADDR_W-1:0] rd_q;
    logic [RADDR_W-1:0] rs1_q;
    logic [RADDR_W-1:0] rs2_q;
    logic [XLEN-1:0]    rd1_q;
    logic [XLEN-1:0]    rd2_q;
    logic [XLEN-1:0]    imm_q;

    logic [XLEN-1:0]    fwd_a;
    logic [XLEN-1:0]    fwd_b;
    logic               bubble;

    // EX/MEM is newer than MEM/WB, so it is checked first; x0 is never a source.
    always_comb begin
        fwd_a = rd1_q;
        if (ex_mem_RegWrite && (ex_mem_rd != '0) && (ex_mem_rd == rs1_q)) begin
            fwd_a = ex_mem_result;
        end else if (mem_wb_RegWrite && (mem_wb_rd != '0) && (mem_wb_rd == rs1_q)) begin
            fwd_a = mem_wb_data;
        end
    end

    always_comb begin
        fwd_b = rd2_q;
        if (ex_mem_RegWrite && (ex_mem_rd != '0) && (ex_mem_rd == rs2_q)) begin
            fwd_b = ex_mem_result;
        end else if (mem_wb_RegWrite && (mem_wb_rd != '0) && (mem_wb_rd == rs2_q)) begin
            fwd_b = mem_wb_data;
        end
    end

    // rs2 match is deliberately conservative: stores read rs2 even with ALUSrc set.
    always_comb begin
        load_use_stall = id_valid && valid_q && memread_q && (rd_q != '0) &&
                         ((rd_q == id_rs1) || (rd_q == id_rs2)) && !flush_i;
    end

    assign bubble = !hold_i && (flush_i || load_use_stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
        end else if (hold_i) begin
            // Refresh operands so a forwarding source retiring during the hold is not lost.
            rd1_q <= fwd_a;
            rd2_q <= fwd_b;
        end else if (flush_i || load_use_stall) begin
            valid_q    <= 1'b0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
        end else begin
            valid_q    <= id_valid;
            alusrc_q   <= id_valid && id_ALUSrc;
            regwrite_q <= id_valid && id_RegWrite;
            memread_q  <= id_valid && id_MemRead;
            rd_q       <= id_rd;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd1_q      <= id_RD1;
            rd2_q      <= id_RD2;
            imm_q      <= id_imm;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

    assign ex_valid    = valid_q;
    assign ex_ALUSrc   = alusrc_q;
    assign ex_RegWrite = regwrite_q;
    assign ex_MemRead  = memread_q;
    assign ex_rd       = rd_q;
    assign ex_A        = fwd_a;
    assign ex_RD2      = fwd_b;
    assign ex_imm      = imm_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage: reset, forwarding priority,
// load-use bubble, hold refresh, flush priority and the x0 guard.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        hold_i;
    logic        flush_i;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_RD1, id_RD2, id_imm;
    logic        id_ALUSrc, id_RegWrite, id_MemRead;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_RegWrite;
    logic [31:0] ex_mem_result;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_RegWrite;
    logic [31:0] mem_wb_data;
    logic        ex_valid, ex_ALUSrc, ex_RegWrite, ex_MemRead;
    logic [4:0]  ex_rd;
    logic [31:0] ex_A, ex_RD2, ex_imm;
    logic        load_use_stall;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_operand_stage dut (
        .clk             (clk),
        .rst             (rst),
        .hold_i          (hold_i),
        .flush_i         (flush_i),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_RD1          (id_RD1),
        .id_RD2          (id_RD2),
        .id_imm          (id_imm),
        .id_ALUSrc       (id_ALUSrc),
        .id_RegWrite     (id_RegWrite),
        .id_MemRead      (id_MemRead),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_RegWrite (ex_mem_RegWrite),
        .ex_mem_result   (ex_mem_result),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_RegWrite (mem_wb_RegWrite),
        .mem_wb_data     (mem_wb_data),
        .ex_valid        (ex_valid),
        .ex_ALUSrc       (ex_ALUSrc),
        .ex_RegWrite     (ex_RegWrite),
        .ex_MemRead      (ex_MemRead),
        .ex_rd           (ex_rd),
        .ex_A            (ex_A),
        .ex_RD2          (ex_RD2),
        .ex_imm          (ex_imm),
        .load_use_stall  (load_use_stall)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .bubble_cnt      (bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] imm, input logic alusrc, input logic regw,
                            input logic memr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_RD1 = rd1; id_RD2 = rd2; id_imm = imm;
        id_ALUSrc = alusrc; id_RegWrite = regw; id_MemRead = memr;
    endtask

    initial begin
        rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
        drive_id(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
                 5'($urandom_range(31, 0)), $urandom(), $urandom(), $urandom(),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1);
        ex_mem_rd = '0; ex_mem_RegWrite = 1'b0; ex_mem_result = '0;
        mem_wb_rd = '0; mem_wb_RegWrite = 1'b0; mem_wb_data = '0;

        // Reset
        tick(); tick();
        check("rst_valid",   32'(ex_valid), 32'd0);
        check("rst_alusrc",  32'(ex_ALUSrc), 32'd0);
        check("rst_regw",    32'(ex_RegWrite), 32'd0);
        check("rst_memr",    32'(ex_MemRead), 32'd0);
        check("rst_rd",      32'(ex_rd), 32'd0);
        check("rst_A",       ex_A, 32'd0);
        check("rst_RD2",     ex_RD2, 32'd0);
        check("rst_imm",     ex_imm, 32'd0);
        check("rst_stall",   32'(load_use_stall), 32'd0);

        // addi x5,x0,7
        rst = 1'b0;
        drive_id(1'b1, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'd7, 1'b1, 1'b1, 1'b0);
        tick();
        check("addi_valid",  32'(ex_valid), 32'd1);
        check("addi_rd",     32'(ex_rd), 32'd5);
        check("addi_imm",    ex_imm, 32'd7);
        check("addi_alusrc", 32'(ex_ALUSrc), 32'd1);
        check("addi_A",      ex_A, 32'd0);

        // add x6,x5,x5 with stale register-file data
        drive_id(1'b1, 5'd5, 5'd5, 5'd6, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        ex_mem_rd = 5'd5; ex_mem_RegWrite = 1'b1; ex_mem_result = 32'd7;
        #1;
        check("fwd_exmem_A",   ex_A, 32'd7);
        check("fwd_exmem_RD2", ex_RD2, 32'd7);
        mem_wb_rd = 5'd5; mem_wb_RegWrite = 1'b1; mem_wb_data = 32'd3;
        #1;
        check("fwd_prio_A",    ex_A, 32'd7);
        check("fwd_prio_RD2",  ex_RD2, 32'd7);
        ex_mem_RegWrite = 1'b0;
        #1;
        check("fwd_memwb_A",   ex_A, 32'd3);

        // id_valid = 0 forces controls to zero
        tick();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_regw",  32'(ex_RegWrite), 32'd0);
        mem_wb_RegWrite = 1'b0; mem_wb_rd = '0;

        // lw x8 then a store reading rs2 = 8 with ALUSrc = 1
        drive_id(1'b1, 5'd2, 5'd0, 5'd8, 32'h40, 32'd0, 32'd4, 1'b1, 1'b1, 1'b1);
        tick();
        check("lw_memr", 32'(ex_MemRead), 32'd1);
        drive_id(1'b1, 5'd3, 5'd8, 5'd0, 32'h100, 32'hDEAD, 32'd8, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_stall", 32'(load_use_stall), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_regw",  32'(ex_RegWrite), 32'd0);
        check("lu_stall_once",   32'(load_use_stall), 32'd0);
        tick();
        mem_wb_rd = 5'd8; mem_wb_RegWrite = 1'b1; mem_wb_data = 32'h1234;
        #1;
        check("lu_after_valid", 32'(ex_valid), 32'd1);
        check("lu_after_RD2",   ex_RD2, 32'h1234);
        check("lu_after_A",     ex_A, 32'h100);

        // Hold refresh: rs1 = 9 forwarded from MEM/WB
        drive_id(1'b1, 5'd9, 5'd0, 5'd11, 32'hAAAA, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        mem_wb_RegWrite = 1'b0;
        tick();
        mem_wb_rd = 5'd9; mem_wb_RegWrite = 1'b1; mem_wb_data = 32'h55;
        #1;
        check("hold_pre_A", ex_A, 32'h55);
        hold_i = 1'b1;
        drive_id(1'b1, 5'd1, 5'd1, 5'd12, 32'h77, 32'h77, 32'h77, 1'b0, 1'b1, 1'b0);
        tick();
        mem_wb_rd = 5'd0; mem_wb_RegWrite = 1'b0; mem_wb_data = 32'h99;
        #1;
        check("hold_c1_A", ex_A, 32'h55);
        tick();
        check("hold_c2_A", ex_A, 32'h55);
        tick();
        check("hold_c3_A",  ex_A, 32'h55);
        check("hold_c3_rd", 32'(ex_rd), 32'd11);
        hold_i = 1'b0;

        // Flush priority over load-use: lw x10 in EX, consumer rs1 = 10 in ID
        drive_id(1'b1, 5'd2, 5'd0, 5'd10, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd10, 5'd0, 5'd13, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("fl_stall_noflush", 32'(load_use_stall), 32'd1);
        flush_i = 1'b1;
        #1;
        check("fl_stall_flush", 32'(load_use_stall), 32'd0);
        hold_i = 1'b1;
        tick();
        check("fl_hold_valid", 32'(ex_valid), 32'd1);
        check("fl_hold_rd",    32'(ex_rd), 32'd10);
        check("fl_hold_memr",  32'(ex_MemRead), 32'd1);
        hold_i = 1'b0;
        tick();
        flush_i = 1'b0;
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_regw",  32'(ex_RegWrite), 32'd0);
        check("fl_rd",    32'(ex_rd), 32'd0);

        // x0 guard
        drive_id(1'b1, 5'd0, 5'd0, 5'd14, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        ex_mem_rd = 5'd0; ex_mem_RegWrite = 1'b1; ex_mem_result = 32'hFFFF_FFFF;
        mem_wb_rd = 5'd0; mem_wb_RegWrite = 1'b1; mem_wb_data = 32'hFFFF_FFFF;
        #1;
        check("x0_A",   ex_A, 32'd0);
        check("x0_RD2", ex_RD2, 32'd0);

        // Reset applied mid-hold discards the instruction
        ex_mem_RegWrite = 1'b0; mem_wb_RegWrite = 1'b0;
        hold_i = 1'b1; rst = 1'b1;
        tick();
        check("rst_hold_valid", 32'(ex_valid), 32'd0);
        check("rst_hold_rd",    32'(ex_rd), 32'd0);
        rst = 1'b0; hold_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage that produces the EX-side operands: ALU operand A, rs2 data (RD2), imm and ALUSrc.
- Its outputs feed the rs2/imm operand-B mux, the ALU and the store-data path.
- Registers the decode-stage operands and controls, forwards rs1/rs2 from EX/MEM and MEM/WB, detects load-use hazards, and inserts bubbles on flush or load-use.
- Refreshes the held operands during an external hold so forwarded data is not lost.

Parameters:
- XLEN, 32, data width of operands and results.
- RADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- hold_i  in  1  external freeze of EX (memory wait).
- flush_i  in  1  branch taken: kill the instruction entering EX.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  in  RADDR_W  register indices.
- id_RD1, id_RD2  in  XLEN  register-file read data.
- id_imm  in  XLEN  extended immediate.
- id_ALUSrc, id_RegWrite, id_MemRead  in  1  decode controls.
- ex_mem_rd  in  RADDR_W;  ex_mem_RegWrite  in  1;  ex_mem_result  in  XLEN.
- mem_wb_rd  in  RADDR_W;  mem_wb_RegWrite  in  1;  mem_wb_data  in  XLEN.
- ex_valid, ex_ALUSrc, ex_RegWrite, ex_MemRead  out  1  registered controls.
- ex_rd  out  RADDR_W  registered destination register.
- ex_A  out  XLEN  forwarded rs1 value.
- ex_RD2  out  XLEN  forwarded rs2 value, to the operand-B mux and store data.
- ex_imm  out  XLEN  registered immediate.
- load_use_stall  out  1  freeze PC and IF/ID, combinational.

Behaviour:
- Reset: all registered outputs are 0, and rs1/rs2 index registers are 0. Reset applied mid-hold or mid-stall discards the instruction.
- Forwarding (combinational, from the registered rs1_q/rs2_q and RD1_q/RD2_q), evaluated per operand:
  - if ex_mem_RegWrite && ex_mem_rd != 0 && ex_mem_rd == rsX_q, use ex_mem_result;
  - else if mem_wb_RegWrite && mem_wb_rd != 0 && mem_wb_rd == rsX_q, use mem_wb_data;
  - else use RDX_q.
  - EX/MEM always beats MEM/WB. Register x0 is never forwarded.
- Load-use: load_use_stall = id_valid && ex_valid && ex_MemRead && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2) && !flush_i.
  - The rs2 match is conservative: it applies even when id_ALUSrc = 1, because stores read rs2.
  - Invariant: the resulting bubble guarantees a load in EX/MEM is never a forwarding source.
- Register update at each clk edge, in priority order:
  1. rst: clear.
  2. hold_i: all fields hold, except RD1_q/RD2_q, which load the current forwarded ex_A/ex_RD2 (operand refresh).
  3. flush_i: insert a bubble. ex_valid = ex_RegWrite = ex_MemRead = 0 and ex_rd = 0; data fields are don't-care but are cleared.
  4. load_use_stall: insert a bubble, same as flush.
  5. Otherwise capture all id_* fields. When id_valid = 0, controls are forced to 0.
- Simultaneous events:
  - flush_i with hold_i: hold wins; the flush source must keep flush_i asserted.
  - flush_i with load-use: stall is suppressed and the bubble comes from flush.
  - load_use_stall is independent of hold_i. The upstream stage ORs it with hold.
- Latency: one cycle from ID to EX outputs. Forwarding adds no cycle.
- Load-use stall lasts exactly one cycle per hazard, unless hold_i extends it.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- When defined:
  - adds output bubble_cnt (32 bits), reset to 0;
  - increments once per edge at which a bubble is inserted by flush or load-use, with hold_i = 0;
  - wraps from 0xFFFFFFFF to 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst for 2 cycles with random id_* inputs. All outputs read 0 and load_use_stall = 0.
- Back-to-back ALU forwarding: `addi x5,x0,7` then `add x6,x5,x5`.
  - With ex_mem_rd = 5, ex_mem_result = 7, ex_A = ex_RD2 = 7.
  - With mem_wb_rd = 5, mem_wb_data = 3 also driven, ex_mem still wins (7).
- Load-use: EX holds `lw x8` (ex_MemRead = 1), ID has rs2 = 8 with id_ALUSrc = 1.
  - load_use_stall = 1 for one cycle; the next EX has ex_valid = 0.
  - After the bubble, ex_RD2 = mem_wb_data = 0x1234.
- Hold refresh: EX operand rs1 = 9 forwarded from MEM/WB value 0x55. Hold for 3 cycles while MEM/WB changes to rd = 0 (bubble). ex_A stays 0x55.
- Flush priority: flush_i and a load-use condition in the same cycle.
  - load_use_stall = 0; next ex_valid = 0 and ex_RegWrite = 0.
  - With hold_i also high, EX contents are unchanged.
- x0 guard: ex_mem_rd = 0, ex_mem_RegWrite = 1, result 0xFFFFFFFF, consumer rs1 = 0. ex_A = id_RD1 = 0.
